alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Multicycle sequencer for the Stage5 execute block. It accepts one
//   operation at a time over a start/done handshake and drives the Stage5
//   control inputs (ALU source muxes, ALU operation, ALU output register load,
//   SR write). Conditional branches read back the SR zero flag.
//
//   Optional feature macro: ALU_SEQ_BRANCH_EN
//     defined   -> BEQ/BNE supported (CMP/EVAL/TARGET states compiled in)
//     undefined -> ops 6/7 are illegal and taken stays 0
//
// Ports
//   CLK      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   operation request, sampled only in IDLE
//   op       in   operation code, captured on accept
//   SRout    in   Stage5 flags: [1]=zero, [0]=negative
//   ALUsrcA  out  00 MDRout, 01 immGenOut, 10 CCout
//   ALUsrcB  out  00 const 2, 01 reggieOut, 10 immGenOut, 11 const 0
//   ALUop    out  00 add, 01 and, 10 or, 11 subtract (B - A)
//   ALU_in   out  load ALU output register at end of cycle
//   SRw      out  write SR at end of cycle
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse
//   taken    out  branch-taken result, held until next accept
//   illegal  out  unsupported op, held until next accept
module alu_seq_ctrl #(
    parameter int OPW = 4
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic           start,
    input  logic [OPW-1:0] op,
    input  logic [1:0]     SRout,
    output logic [1:0]     ALUsrcA,
    output logic [1:0]     ALUsrcB,
    output logic [1:0]     ALUop,
    output logic           ALU_in,
    output logic           SRw,
    output logic           busy,
    output logic           done,
    output logic           taken,
    output logic           illegal
);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(4);
    localparam logic [OPW-1:0] OP_CMP  = OPW'(5);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(7);
    localparam logic [OPW-1:0] OP_INC  = OPW'(8);

    localparam logic [1:0] A_MDR = 2'b00;
    localparam logic [1:0] A_IMM = 2'b01;
    localparam logic [1:0] A_CC  = 2'b10;
    localparam logic [1:0] B_C2  = 2'b00;
    localparam logic [1:0] B_REG = 2'b01;
    localparam logic [1:0] B_IMM = 2'b10;
    localparam logic [1:0] F_ADD = 2'b00;
    localparam logic [1:0] F_AND = 2'b01;
    localparam logic [1:0] F_OR  = 2'b10;
    localparam logic [1:0] F_SUB = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
`ifdef ALU_SEQ_BRANCH_EN
        S_CMP,
        S_EVAL,
        S_TARGET,
`endif
        S_DONE
    } state_t;

    state_t         state, nxt;
    logic [OPW-1:0] op_q;
    logic           taken_q;
    logic           illegal_q;
    logic           accept;
    logic           br_taken;
    logic           unused_sr;

    function automatic logic is_branch(input logic [OPW-1:0] o);
`ifdef ALU_SEQ_BRANCH_EN
        return (o == OP_BEQ) || (o == OP_BNE);
`else
        return (o != o);
`endif
    endfunction

    function automatic logic is_alu(input logic [OPW-1:0] o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND) || (o == OP_OR) ||
               (o == OP_ADDI) || (o == OP_CMP) || (o == OP_INC);
    endfunction

    assign accept = (state == S_IDLE) && start;

    // Zero flag decides both branch flavours; negative flag has no consumer here.
    assign br_taken  = (op_q == OP_BEQ) ? SRout[1] : !SRout[1];
    assign unused_sr = ^SRout;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                op_q      <= op;
                taken_q   <= 1'b0;
                illegal_q <= !(is_alu(op) || is_branch(op));
            end
`ifdef ALU_SEQ_BRANCH_EN
            else if (state == S_EVAL && br_taken) begin
                taken_q <= 1'b1;
            end
`endif
        end
    end

    always_comb begin
        nxt     = state;
        ALUsrcA = 2'b00;
        ALUsrcB = 2'b00;
        ALUop   = 2'b00;
        ALU_in  = 1'b0;
        SRw     = 1'b0;
        done    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (is_branch(op)) begin
`ifdef ALU_SEQ_BRANCH_EN
                        nxt = S_CMP;
`endif
                    end else if (is_alu(op)) begin
                        nxt = S_EXEC;
                    end else begin
                        nxt = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                ALU_in = 1'b1;
                case (op_q)
                    OP_ADD:  begin ALUsrcA = A_MDR; ALUsrcB = B_REG; ALUop = F_ADD; end
                    OP_SUB:  begin ALUsrcA = A_MDR; ALUsrcB = B_REG; ALUop = F_SUB; end
                    OP_AND:  begin ALUsrcA = A_MDR; ALUsrcB = B_REG; ALUop = F_AND; end
                    OP_OR:   begin ALUsrcA = A_MDR; ALUsrcB = B_REG; ALUop = F_OR;  end
                    OP_ADDI: begin ALUsrcA = A_IMM; ALUsrcB = B_REG; ALUop = F_ADD; end
                    OP_INC:  begin ALUsrcA = A_CC;  ALUsrcB = B_C2;  ALUop = F_ADD; end
                    OP_CMP: begin
                        // Compare only updates flags; the result register keeps its value.
                        ALUsrcA = A_MDR;
                        ALUsrcB = B_REG;
                        ALUop   = F_SUB;
                        ALU_in  = 1'b0;
                        SRw     = 1'b1;
                    end
                    default: ALU_in = 1'b0;
                endcase
                nxt = S_DONE;
            end
`ifdef ALU_SEQ_BRANCH_EN
            S_CMP: begin
                ALUsrcA = A_MDR;
                ALUsrcB = B_REG;
                ALUop   = F_SUB;
                SRw     = 1'b1;
                nxt     = S_EVAL;
            end
            // SR written at the end of CMP is visible on SRout here.
            S_EVAL: begin
                nxt = br_taken ? S_TARGET : S_DONE;
            end
            S_TARGET: begin
                ALUsrcA = A_CC;
                ALUsrcB = B_IMM;
                ALUop   = F_ADD;
                ALU_in  = 1'b1;
                nxt     = S_DONE;
            end
`endif
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign taken   = taken_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//   Directed bench for alu_seq_ctrl with a small behavioural Stage5 datapath
//   (operand registers, ALU, output register, SR) closed around the DUT.
//   Expected completions are queued when an operation is issued and popped
//   when done is seen. Works with and without ALU_SEQ_BRANCH_EN.
module tb_alu_seq_ctrl;

    logic       CLK = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] op;
    logic [1:0] SRout;
    logic [1:0] ALUsrcA, ALUsrcB, ALUop;
    logic       ALU_in, SRw, busy, done, taken, illegal;

    always #5 CLK = ~CLK;

    alu_seq_ctrl #(.OPW(4)) dut (
        .CLK(CLK), .reset(reset), .start(start), .op(op), .SRout(SRout),
        .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUop(ALUop),
        .ALU_in(ALU_in), .SRw(SRw), .busy(busy), .done(done),
        .taken(taken), .illegal(illegal)
    );

    // Stage5 model
    logic [15:0] mdr, regv, imm, cc;
    logic [15:0] a_v, b_v, res;
    logic [15:0] alu_out_q = 16'h0000;
    logic [1:0]  sr_q = 2'b00;

    always_comb begin
        a_v = 16'h0000;
        b_v = 16'h0000;
        res = 16'h0000;
        case (ALUsrcA)
            2'b00: a_v = mdr;
            2'b01: a_v = imm;
            2'b10: a_v = cc;
            default: a_v = 16'h0000;
        endcase
        case (ALUsrcB)
            2'b00: b_v = 16'h0002;
            2'b01: b_v = regv;
            2'b10: b_v = imm;
            default: b_v = 16'h0000;
        endcase
        case (ALUop)
            2'b00: res = a_v + b_v;
            2'b01: res = a_v & b_v;
            2'b10: res = a_v | b_v;
            default: res = b_v - a_v;
        endcase
    end

    always @(posedge CLK) begin
        if (ALU_in) alu_out_q <= res;
        if (SRw)    sr_q <= {res == 16'h0000, res[15]};
    end
    assign SRout = sr_q;

    int n_aluin = 0, n_srw = 0, n_done = 0;
    always @(posedge CLK) begin
        if (ALU_in) n_aluin <= n_aluin + 1;
        if (SRw)    n_srw   <= n_srw + 1;
        if (done)   n_done  <= n_done + 1;
    end

    typedef struct {
        int          lat;
        logic        tk;
        logic        il;
        logic [15:0] alu;
        int          lds;
        int          sws;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_alu = 16'h0000;
    int          nchk = 0;
    int          nfail = 0;
    logic [1:0]  c1_a, c1_b, c1_op;
    logic        c1_ld, c1_sw, c1_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one operation against the current operand values.
    function automatic exp_t predict(input logic [3:0] o);
        exp_t e;
        e.lat = 2; e.tk = 1'b0; e.il = 1'b0; e.lds = 1; e.sws = 0;
        case (o)
            4'd0: exp_alu = regv + mdr;
            4'd1: exp_alu = regv - mdr;
            4'd2: exp_alu = regv & mdr;
            4'd3: exp_alu = regv | mdr;
            4'd4: exp_alu = regv + imm;
            4'd5: begin e.lds = 0; e.sws = 1; end
            4'd8: exp_alu = cc + 16'h0002;
`ifdef ALU_SEQ_BRANCH_EN
            4'd6, 4'd7: begin
                e.tk  = (o == 4'd6) ? (regv == mdr) : (regv != mdr);
                e.sws = 1;
                if (e.tk) begin
                    e.lat = 4; e.lds = 1; exp_alu = cc + imm;
                end else begin
                    e.lat = 3; e.lds = 0;
                end
            end
`endif
            default: begin e.lat = 1; e.il = 1'b1; e.lds = 0; end
        endcase
        e.alu = exp_alu;
        return e;
    endfunction

    task automatic issue(input logic [3:0] o, input bit hold);
        exp_t e, got;
        int   cyc, ld0, sw0;
        e = predict(o);
        sb.push_back(e);
        @(negedge CLK);
        start = 1'b1;
        op    = o;
        ld0   = n_aluin;
        sw0   = n_srw;
        @(negedge CLK);
        if (!hold) start = 1'b0;
        c1_a = ALUsrcA; c1_b = ALUsrcB; c1_op = ALUop;
        c1_ld = ALU_in; c1_sw = SRw; c1_busy = busy;
        cyc = 1;
        while (done !== 1'b1 && cyc < 10) begin
            @(negedge CLK);
            cyc++;
        end
        if (sb.size() == 0) begin
            chk("scoreboard empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            chk($sformatf("latency op%0d", o), cyc, got.lat);
            chk($sformatf("taken op%0d", o), {31'd0, taken}, {31'd0, got.tk});
            chk($sformatf("illegal op%0d", o), {31'd0, illegal}, {31'd0, got.il});
            chk($sformatf("aluout op%0d", o), {16'd0, alu_out_q}, {16'd0, got.alu});
            chk($sformatf("ALU_in pulses op%0d", o), n_aluin - ld0, got.lds);
            chk($sformatf("SRw pulses op%0d", o), n_srw - sw0, got.sws);
        end
        if (hold) begin
            // keep start high across the edge that ends DONE
            @(posedge CLK);
            #1 start = 1'b0;
            @(negedge CLK);
            chk($sformatf("start ignored while busy op%0d", o), {31'd0, busy}, 32'd0);
        end else begin
            start = 1'b0;
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " ctrl"}, {24'd0, ALUsrcA, ALUsrcB, ALUop, ALU_in, SRw}, 32'd0);
        chk({tag, " flags"}, {30'd0, taken, illegal}, 32'd0);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        start = 1'b1;
        op    = 4'd0;
        mdr = 16'h0000; regv = 16'h0000; imm = 16'h0000; cc = 16'h0000;

        // reset held two cycles with start asserted
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        start = 1'b0;
        chk_quiet("reset");
        @(negedge CLK);
        chk_quiet("post-reset idle");

        // SUB with equal operands
        mdr = 16'hABCD; regv = 16'hABCD;
        issue(4'd1, 1'b0);
        chk("SUB c1 ctrl", {26'd0, c1_a, c1_b, c1_op}, {26'd0, 2'b00, 2'b01, 2'b11});
        chk("SUB c1 ALU_in/SRw", {30'd0, c1_ld, c1_sw}, {30'd0, 1'b1, 1'b0});
        chk("SUB c1 busy", {31'd0, c1_busy}, 32'd1);

        // plain ALU ops with distinct operands
        mdr = 16'h1234; regv = 16'h0F0F; imm = 16'h0101; cc = 16'h0010;
        issue(4'd0, 1'b0);
        chk("ADD c1 ctrl", {26'd0, c1_a, c1_b, c1_op}, {26'd0, 2'b00, 2'b01, 2'b00});
        issue(4'd2, 1'b0);
        issue(4'd3, 1'b0);
        issue(4'd4, 1'b0);
        chk("ADDI c1 ctrl", {26'd0, c1_a, c1_b, c1_op}, {26'd0, 2'b01, 2'b01, 2'b00});
        issue(4'd8, 1'b1);
        chk("INC c1 ctrl", {26'd0, c1_a, c1_b, c1_op}, {26'd0, 2'b10, 2'b00, 2'b00});

        // CMP with equal operands
        mdr = 16'h5555; regv = 16'h5555;
        issue(4'd5, 1'b0);
        chk("CMP c1 ALU_in/SRw", {30'd0, c1_ld, c1_sw}, {30'd0, 1'b0, 1'b1});
        chk("CMP SRout", {30'd0, SRout}, {30'd0, 2'b10});

        // branches with equal operands
        cc = 16'h0010; imm = 16'h0004;
        issue(4'd6, 1'b0);
`ifdef ALU_SEQ_BRANCH_EN
        @(negedge CLK);
        chk("taken held in idle", {31'd0, taken}, 32'd1);
`endif
        issue(4'd7, 1'b0);

        // illegal op, start held high while busy
        issue(4'hF, 1'b1);
        issue(4'd0, 1'b1);

        // abort: reset mid-operation
        mdr = 16'h0007; regv = 16'h0007;
        @(negedge CLK);
        d0 = n_done;
`ifdef ALU_SEQ_BRANCH_EN
        start = 1'b1; op = 4'd6;
        @(negedge CLK);            // CMP
        start = 1'b0;
        @(negedge CLK);            // EVAL
        reset = 1'b1;
`else
        start = 1'b1; op = 4'd5;
        @(negedge CLK);            // EXEC
        start = 1'b0;
        reset = 1'b1;
`endif
        @(negedge CLK);
        reset = 1'b0;
        chk_quiet("abort");
        repeat (3) @(negedge CLK);
        chk("abort no done", n_done - d0, 0);

        mdr = 16'h0003; regv = 16'h0040;
        issue(4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
